// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit between the EX stage and DataMemory.
// Accepts one request per handshake, forms ea = base + sext(imm12), screens
// illegal/out-of-range/misaligned requests, sequences the DataMemory access,
// and returns load data or a status code with saturating statistics counters.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_*                    request handshake and operands from EX
//   resp_*                   response handshake, load data, status code
//   MemWrite .. WriteData    DataMemory control/address/data
//   ReadData                 DataMemory read data (already size-extended)
//   cnt_loads/stores/faults  saturating access counters
module lsu_mem_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_base,
  input  logic [11:0]      req_imm,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [1:0]       resp_err,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             one_byte,
  output logic             two_byte,
  output logic             four_bytes,
  output logic             unsigned_load,
  output logic [DEPTH-1:0] Address,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [CNT_W-1:0] cnt_loads,
  output logic [CNT_W-1:0] cnt_stores,
  output logic [CNT_W-1:0] cnt_faults
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

  state_e             state_q, state_d;
  logic               is_store_q;
  logic [2:0]         funct3_q;
  logic [DEPTH-1:0]   addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt_loads_q, cnt_stores_q, cnt_faults_q;

  logic [WIDTH-1:0]   ea;
  logic               accept;
  logic               illegal, out_of_range, misaligned;
  logic [1:0]         acc_err;
  logic               active;

  assign ea     = req_base + {{(WIDTH-12){req_imm[11]}}, req_imm};
  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_is_store;  // no unsigned stores
      default:                illegal = 1'b1;
    endcase
    out_of_range = |ea[WIDTH-1:DEPTH];
    misaligned   = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                   ((req_funct3 == 3'b010) && (ea[1:0] != 2'b00));
    if (illegal)           acc_err = 2'b11;
    else if (out_of_range) acc_err = 2'b10;
    else if (misaligned)   acc_err = 2'b01;
    else                   acc_err = 2'b00;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (req_valid) state_d = (acc_err != 2'b00) ? StResp : StAccess;
      StAccess:  state_d = is_store_q ? StResp : StCapture;
      StCapture: state_d = StResp;
      StResp:    if (resp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are gated by rst so a reset asserted during ACCESS kills the
  // write before the DataMemory samples it at the reset edge.
  always_comb begin
    active        = rst && ((state_q == StAccess) || (state_q == StCapture));
    req_ready     = (state_q == StIdle);
    resp_valid    = (state_q == StResp);
    MemWrite      = rst && (state_q == StAccess) && is_store_q;
    MemRead       = active && !is_store_q;
    one_byte      = active && (funct3_q[1:0] == 2'b00);
    two_byte      = active && (funct3_q[1:0] == 2'b01);
    four_bytes    = active && (funct3_q[1:0] == 2'b10);
    unsigned_load = active && funct3_q[2];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 2'b00;
      cnt_loads_q  <= '0;
      cnt_stores_q <= '0;
      cnt_faults_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        err_q      <= acc_err;
        rdata_q    <= '0;
        if (acc_err == 2'b00) begin
          // Faulting requests leave the DataMemory-facing address/data alone.
          addr_q  <= ea[DEPTH-1:0];
          wdata_q <= req_wdata;
        end else if (~&cnt_faults_q) begin
          cnt_faults_q <= cnt_faults_q + CNT_W'(1);
        end
      end
      if ((state_q == StAccess) && is_store_q && (~&cnt_stores_q)) begin
        cnt_stores_q <= cnt_stores_q + CNT_W'(1);
      end
      if (state_q == StCapture) begin
        rdata_q <= ReadData;
        if (~&cnt_loads_q) cnt_loads_q <= cnt_loads_q + CNT_W'(1);
      end
    end
  end

  assign Address    = addr_q;
  assign WriteData  = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign cnt_loads  = cnt_loads_q;
  assign cnt_stores = cnt_stores_q;
  assign cnt_faults = cnt_faults_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage with a small byte-wide
// DataMemory model (sync write, combinational size-extended read).
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_base = '0;
  logic [11:0] req_imm = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load;
  logic [11:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [15:0] cnt_loads, cnt_stores, cnt_faults;

  int passed = 0;
  int total  = 0;
  int mw_cnt = 0;
  int mr_cnt = 0;
  logic [11:0] last_addr = '0;
  logic        last_uns  = 1'b0;

  logic [7:0] mem [0:4095];

  always #5 clk = ~clk;

  lsu_mem_stage #(.WIDTH(32), .DEPTH(12), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemWrite(MemWrite), .MemRead(MemRead), .one_byte(one_byte),
    .two_byte(two_byte), .four_bytes(four_bytes), .unsigned_load(unsigned_load),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_faults(cnt_faults)
  );

  // DataMemory model
  int a0, a1, a2, a3;
  always_comb begin
    a0 = int'(Address);
    a1 = (a0 + 1) % 4096;
    a2 = (a0 + 2) % 4096;
    a3 = (a0 + 3) % 4096;
  end

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[a0] <= WriteData[7:0];
      if (two_byte || four_bytes) mem[a1] <= WriteData[15:8];
      if (four_bytes) begin
        mem[a2] <= WriteData[23:16];
        mem[a3] <= WriteData[31:24];
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (four_bytes) ReadData = {mem[a3], mem[a2], mem[a1], mem[a0]};
    else if (two_byte)
      ReadData = unsigned_load ? {16'h0, mem[a1], mem[a0]}
                               : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
    else if (one_byte)
      ReadData = unsigned_load ? {24'h0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
  end

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (MemWrite) mw_cnt++;
    if (MemRead) begin
      mr_cnt++;
      last_uns = unsigned_load;
    end
    if (MemWrite || MemRead) last_addr = Address;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request; lat = cycles from acceptance edge to resp_valid.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                        input logic [11:0] imm, input logic [31:0] wd, output int lat,
                        output int mw, output int mr);
    int mw0, mr0;
    @(negedge clk);
    mw0 = mw_cnt;
    mr0 = mr_cnt;
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_base     = base;
    req_imm      = imm;
    req_wdata    = wd;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    mw = mw_cnt - mw0;
    mr = mr_cnt - mr0;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("req_ready_after_hs", {31'b0, req_ready}, 32'd1);
    check("resp_valid_after_hs", {31'b0, resp_valid}, 32'd0);
  endtask

  int lat, mw, mr;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_cnt_faults", {16'b0, cnt_faults}, 32'd0);
    check("rst_address", {20'b0, Address}, 32'd0);
    rst = 1'b1;

    // Store W then load W at address 0
    do_req(1'b1, 3'b010, 32'h0, 12'h000, 32'hDEADBEEF, lat, mw, mr);
    check("sw_latency", lat, 32'd2);
    check("sw_err", {30'b0, resp_err}, 32'd0);
    check("sw_memwrite_cycles", mw, 32'd1);
    finish_resp();
    do_req(1'b0, 3'b010, 32'h0, 12'h000, 32'h0, lat, mw, mr);
    check("lw_latency", lat, 32'd3);
    check("lw_rdata", resp_rdata, 32'hDEADBEEF);
    check("lw_memwrite_cycles", mw, 32'd0);
    check("cnt_stores_1", {16'b0, cnt_stores}, 32'd1);
    check("cnt_loads_1", {16'b0, cnt_loads}, 32'd1);
    finish_resp();

    // Store B at base 0x10 imm -12, then LB / LBU
    do_req(1'b1, 3'b000, 32'h10, 12'hFF4, 32'h000000FF, lat, mw, mr);
    check("sb_address", {20'b0, last_addr}, 32'h004);
    check("sb_rdata_zero", resp_rdata, 32'h0);
    finish_resp();
    do_req(1'b0, 3'b000, 32'h4, 12'h000, 32'h0, lat, mw, mr);
    check("lb_rdata", resp_rdata, 32'hFFFFFFFF);
    check("lb_unsigned", {31'b0, last_uns}, 32'd0);
    finish_resp();
    do_req(1'b0, 3'b100, 32'h4, 12'h000, 32'h0, lat, mw, mr);
    check("lbu_rdata", resp_rdata, 32'h000000FF);
    check("lbu_unsigned", {31'b0, last_uns}, 32'd1);
    check("lbu_address", {20'b0, last_addr}, 32'h004);
    finish_resp();

    // Faulting requests
    do_req(1'b0, 3'b001, 32'h9, 12'h000, 32'h0, lat, mw, mr);
    check("lh_mis_err", {30'b0, resp_err}, 32'd1);
    check("lh_mis_latency", lat, 32'd1);
    check("lh_mis_strobes", mw + mr, 32'd0);
    finish_resp();
    do_req(1'b0, 3'b010, 32'h0, 12'h00E, 32'h0, lat, mw, mr);
    check("lw_mis_err", {30'b0, resp_err}, 32'd1);
    check("lw_mis_strobes", mw + mr, 32'd0);
    finish_resp();
    do_req(1'b0, 3'b010, 32'h1000, 12'h000, 32'h0, lat, mw, mr);
    check("lw_range_err", {30'b0, resp_err}, 32'd2);
    check("lw_range_rdata", resp_rdata, 32'h0);
    check("lw_range_strobes", mw + mr, 32'd0);
    finish_resp();
    do_req(1'b1, 3'b100, 32'h0, 12'h000, 32'h12345678, lat, mw, mr);
    check("sw_illegal_err", {30'b0, resp_err}, 32'd3);
    check("sw_illegal_strobes", mw + mr, 32'd0);
    check("cnt_faults_4", {16'b0, cnt_faults}, 32'd4);
    finish_resp();

    // Load W with response back-pressure; stray requests must be ignored
    do_req(1'b0, 3'b010, 32'h0, 12'h000, 32'h0, lat, mw, mr);
    check("stall_latency", lat, 32'd3);
    mw = mw_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid    = (i == 1 || i == 3);
      req_is_store = 1'b1;
      req_funct3   = 3'b010;
      req_base     = 32'h40;
      req_imm      = 12'h000;
      req_wdata    = 32'h55555555;
      @(posedge clk);
      #1;
      check("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    check("stall_no_write", mw_cnt - mw, 32'd0);
    finish_resp();
    check("stall_cnt_stores", {16'b0, cnt_stores}, 32'd2);
    check("stall_cnt_loads", {16'b0, cnt_loads}, 32'd4);

    // Reset during the ACCESS cycle of a store
    do_req(1'b1, 3'b010, 32'h20, 12'h000, 32'h11223344, lat, mw, mr);
    finish_resp();
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_base     = 32'h20;
    req_imm      = 12'h000;
    req_wdata    = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_mid_memwrite", {31'b0, MemWrite}, 32'd0);
    check("rst_mid_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_mid_counters", {cnt_stores, cnt_loads}, 32'd0);
    check("rst_mid_mem_word", {mem[32'h23], mem[32'h22], mem[32'h21], mem[32'h20]},
          32'h11223344);

    // Fault counter saturation
    @(negedge clk);
    force dut.cnt_faults_q = 16'hFFFE;
    #1;
    release dut.cnt_faults_q;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 3'b011, 32'h0, 12'h000, 32'h0, lat, mw, mr);
      check("sat_err", {30'b0, resp_err}, 32'd3);
      check("sat_cnt_faults", {16'b0, cnt_faults}, 32'h0000FFFF);
      finish_resp();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit sitting between the EX stage and DataMemory.
- Accepts one memory request per handshake, computes the effective address as base + sign-extended imm12, and decodes RISC-V funct3 into DataMemory size/sign controls.
- Screens illegal, out-of-range and misaligned accesses before any memory strobe.
- Sequences the DataMemory access, returns load data or a status code, and keeps saturating access counters.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 12, DataMemory address bits (2^DEPTH bytes).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock; everything updates on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- req_valid  in  1  EX stage presents a request.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_base  in  WIDTH  rs1 value.
- req_imm  in  12  offset, two's complement.
- req_wdata  in  WIDTH  store data (rs2).
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  WIDTH  load result as extended by DataMemory; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal funct3.
- MemWrite  out  1  DataMemory write strobe.
- MemRead  out  1  DataMemory read enable.
- one_byte  out  1  DataMemory byte size select.
- two_byte  out  1  DataMemory halfword size select.
- four_bytes  out  1  DataMemory word size select.
- unsigned_load  out  1  DataMemory zero-extend select.
- Address  out  DEPTH  DataMemory byte address (low DEPTH bits of the effective address).
- WriteData  out  WIDTH  DataMemory write data.
- ReadData  in  WIDTH  DataMemory read data.
- cnt_loads  out  CNT_W  successful loads.
- cnt_stores  out  CNT_W  successful stores.
- cnt_faults  out  CNT_W  requests with resp_err != 00.

Behaviour:
- Reset (rst=0 at an edge) forces, regardless of state:
  - state = IDLE; req_ready = 1; resp_valid = 0.
  - resp_rdata, resp_err, Address, WriteData, all counters = 0.
  - All memory strobes and size selects = 0.
  - Any in-flight request and any pending response are dropped; a MemWrite in progress is deasserted at that edge.
- Address arithmetic:
  - ea = req_base + sign_extend(req_imm), computed modulo 2^32.
  - Request and ea are latched at acceptance (req_valid & req_ready).
- Error checks at acceptance, priority illegal > range > misaligned:
  - Illegal: funct3 in {011, 110, 111}, or a store with funct3 100/101.
  - Out-of-range: ea[31:DEPTH] != 0.
  - Misaligned: H/HU with ea[0] = 1, or W with ea[1:0] != 0.
  - On any error: IDLE -> RESP at the acceptance edge, err set, rdata = 0, cnt_faults++, no memory strobe ever asserted.
- FSM states IDLE, ACCESS, CAPTURE, RESP. Acceptance edge is E0.
  - IDLE: on acceptance with no error -> ACCESS.
  - ACCESS:
    - Size select is one-hot (B/BU -> one_byte, H/HU -> two_byte, W -> four_bytes).
    - unsigned_load = 1 only for BU/HU.
    - Address = ea[DEPTH-1:0]; WriteData = latched wdata.
    - Store: MemWrite = 1 for exactly this one cycle, then -> RESP at E1 with cnt_stores++.
    - Load: MemRead = 1, then -> CAPTURE at E1.
  - CAPTURE (loads only): MemRead and size selects held; ReadData registered into resp_rdata at E2; -> RESP at E2 with cnt_loads++.
  - RESP:
    - resp_valid = 1; rdata/err held stable while resp_ready = 0.
    - On resp_valid & resp_ready -> IDLE; req_ready = 1 on the following cycle.
- Latency from acceptance edge to resp_valid: error 1 cycle, store 2 cycles, load 3 cycles.
- Outside ACCESS/CAPTURE: MemWrite, MemRead, size selects and unsigned_load = 0; Address and WriteData hold their last values.
- Counters saturate at all-ones and never wrap.
- Simultaneous events:
  - req_valid is ignored outside IDLE; no request is queued.
  - Back-to-back: a new request is accepted earliest one cycle after the response handshake.

Test Plan:
- After reset: store W, base 0x0, imm 0, wdata 0xDEADBEEF; then load W at the same address.
  -> Store response err = 00 two cycles after acceptance, with MemWrite high exactly 1 cycle.
  -> Load rdata = 0xDEADBEEF three cycles after acceptance; cnt_stores = 1, cnt_loads = 1.
- Store B 0x000000FF at base 0x10, imm -12 (ea = 0x004); then LB and LBU at the same address.
  -> Address = 0x004; LB rdata = 0xFFFFFFFF; LBU rdata = 0x000000FF (unsigned_load 0 then 1).
- Requests LH at ea 0x009, LW at ea 0x00E, LW at base 0x1000 imm 0, SW with funct3 100.
  -> resp_err = 01, 01, 10, 11 respectively; no MemRead/MemWrite pulses; cnt_faults = 4.
- Load W with resp_ready held 0 for 5 cycles.
  -> resp_valid and rdata stable throughout, req_ready = 0; req_valid pulses in this window are not accepted.
- Assert rst = 0 during the ACCESS cycle of a store.
  -> Next cycle: MemWrite = 0, state IDLE, req_ready = 1, resp_valid = 0, counters = 0, and the target word is unchanged from its pre-store value.
- Preload cnt_faults to 0xFFFE (force), then issue 3 faulting requests.
  -> cnt_faults = 0xFFFF and holds there.
